// File: rtl/gmii_tx_arbiter.sv
// GMII transmit arbiter: merges the ARP and UDP GMII byte streams onto the
// single PHY transmit interface. It uses a request/grant handshake per source
// and round-robins when both sources request at once. The data path is
// registered with one cycle of latency. It enforces the inter-frame gap,
// withdraws unused grants after a timeout and truncates oversize frames.
module gmii_tx_arbiter #(
  parameter int IFG_CYCLES  = 12,
  parameter int GNT_TIMEOUT = 16,
  parameter int MAX_FRAME   = 1530
) (
  input  logic       gmii_txc,
  input  logic       rst,
  input  logic       arp_tx_req,
  output logic       arp_tx_gnt,
  input  logic       arp_gmii_tx_en,
  input  logic [7:0] arp_gmii_txd,
  input  logic       udp_tx_req,
  output logic       udp_tx_gnt,
  input  logic       udp_gmii_tx_en,
  input  logic [7:0] udp_gmii_txd,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       busy,
  output logic       frame_abort
);

  localparam int IFG_W = $clog2(IFG_CYCLES + 1);
  localparam int TO_W  = $clog2(GNT_TIMEOUT + 1);
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(GNT_TIMEOUT - 1);
  localparam logic [10:0]      LEN_MAX  = 11'(MAX_FRAME);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GNT_ARP,
    S_GNT_UDP,
    S_DRAIN,
    S_IFG
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;      // 0 = ARP, 1 = UDP; last source granted
  logic             seen_q, seen_d;        // granted source has started its frame
  logic [10:0]      len_q, len_d;
  logic [IFG_W-1:0] ifg_q, ifg_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             tx_en_q, tx_en_d;
  logic [7:0]       txd_q, txd_d;
  logic             arp_gnt_q, arp_gnt_d;
  logic             udp_gnt_q, udp_gnt_d;
  logic             busy_q, busy_d;
  logic             abort_q, abort_d;

  logic             sel_req;
  logic             sel_en;
  logic [7:0]       sel_txd;

  assign sel_req = owner_q ? udp_tx_req     : arp_tx_req;
  assign sel_en  = owner_q ? udp_gmii_tx_en : arp_gmii_tx_en;
  assign sel_txd = owner_q ? udp_gmii_txd   : arp_gmii_txd;

  // Next-state and registered-output logic. Outputs are derived from the next state so that every port comes straight from a flop.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    seen_d  = seen_q;
    len_d   = len_q;
    ifg_d   = ifg_q;
    to_d    = to_q;
    tx_en_d = 1'b0;
    txd_d   = 8'h00;
    abort_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        seen_d = 1'b0;
        len_d  = 11'd0;
        to_d   = '0;
        ifg_d  = '0;
        if (arp_tx_req && (!udp_tx_req || owner_q)) begin
          state_d = S_GNT_ARP;
          owner_d = 1'b0;
        end else if (udp_tx_req) begin
          state_d = S_GNT_UDP;
          owner_d = 1'b1;
        end
      end

      S_GNT_ARP, S_GNT_UDP: begin
        if (!seen_q) begin
          // A first byte takes priority over a request dropped in the same cycle
          if (sel_en) begin
            seen_d  = 1'b1;
            len_d   = 11'd1;
            tx_en_d = 1'b1;
            txd_d   = sel_txd;
          end else if (!sel_req || to_q == TO_LAST) begin
            state_d = S_IDLE;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end else if (sel_en) begin
          if (len_q == LEN_MAX) begin
            abort_d = 1'b1;
            state_d = S_DRAIN;
          end else begin
            tx_en_d = 1'b1;
            txd_d   = sel_txd;
            if (len_q != 11'h7FF) begin
              len_d = len_q + 11'd1;
            end
          end
        end else begin
          state_d = S_IFG;
          ifg_d   = '0;
        end
      end

      S_DRAIN: begin
        if (!sel_en) begin
          state_d = S_IFG;
          ifg_d   = '0;
        end
      end

      S_IFG: begin
        if (ifg_q == IFG_LAST) begin
          state_d = S_IDLE;
        end else begin
          ifg_d = ifg_q + IFG_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    arp_gnt_d = (state_d == S_GNT_ARP) || (state_d == S_DRAIN && !owner_d);
    udp_gnt_d = (state_d == S_GNT_UDP) || (state_d == S_DRAIN &&  owner_d);
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers; reset leaves UDP as last owner so ARP wins the first tie
  always_ff @(posedge gmii_txc) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b1;
      seen_q    <= 1'b0;
      len_q     <= 11'd0;
      ifg_q     <= '0;
      to_q      <= '0;
      tx_en_q   <= 1'b0;
      txd_q     <= 8'h00;
      arp_gnt_q <= 1'b0;
      udp_gnt_q <= 1'b0;
      busy_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      seen_q    <= seen_d;
      len_q     <= len_d;
      ifg_q     <= ifg_d;
      to_q      <= to_d;
      tx_en_q   <= tx_en_d;
      txd_q     <= txd_d;
      arp_gnt_q <= arp_gnt_d;
      udp_gnt_q <= udp_gnt_d;
      busy_q    <= busy_d;
      abort_q   <= abort_d;
    end
  end

  assign arp_tx_gnt  = arp_gnt_q;
  assign udp_tx_gnt  = udp_gnt_q;
  assign gmii_tx_en  = tx_en_q;
  assign gmii_txd    = txd_q;
  assign busy        = busy_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Testbench for gmii_tx_arbiter: grant vectors from a table, a byte
// scoreboard keyed by expected output cycle, and hand-written sequences for
// timeout, truncation, foreign-source noise and mid-frame reset.
module tb_gmii_tx_arbiter;

  localparam int IFG  = 12;
  localparam int TO   = 16;
  localparam int MAXF = 100;

  logic       gmii_txc = 1'b0;
  logic       rst;
  logic       arp_tx_req, arp_tx_gnt, arp_gmii_tx_en;
  logic [7:0] arp_gmii_txd;
  logic       udp_tx_req, udp_tx_gnt, udp_gmii_tx_en;
  logic [7:0] udp_gmii_txd;
  logic       gmii_tx_en;
  logic [7:0] gmii_txd;
  logic       busy, frame_abort;

  gmii_tx_arbiter #(.IFG_CYCLES(IFG), .GNT_TIMEOUT(TO), .MAX_FRAME(MAXF)) dut (
    .gmii_txc       (gmii_txc),
    .rst            (rst),
    .arp_tx_req     (arp_tx_req),
    .arp_tx_gnt     (arp_tx_gnt),
    .arp_gmii_tx_en (arp_gmii_tx_en),
    .arp_gmii_txd   (arp_gmii_txd),
    .udp_tx_req     (udp_tx_req),
    .udp_tx_gnt     (udp_tx_gnt),
    .udp_gmii_tx_en (udp_gmii_tx_en),
    .udp_gmii_txd   (udp_gmii_txd),
    .gmii_tx_en     (gmii_tx_en),
    .gmii_txd       (gmii_txd),
    .busy           (busy),
    .frame_abort    (frame_abort)
  );

  always #4 gmii_txc = ~gmii_txc;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic arp_req;
    logic udp_req;
    logic fresh;
    int   len;
    logic exp_arp_gnt;
    logic exp_udp_gnt;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   abort_cnt = 0;
  int   abort_cyc = -1;
  int   idle_run = 0;
  bit   have_frame = 1'b0;
  logic prev_en = 1'b0;

  // Posedge counter used to stamp expected output cycles
  always @(posedge gmii_txc) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge gmii_txc);
  endtask

  // Output monitor: scoreboard bytes, idle txd, gap length, grant exclusivity, abort pulses
  always @(negedge gmii_txc) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL out byte missing: got none at cycle %0d expected %02h at cycle %0d",
               cyc, sb[0].data, sb[0].cyc);
      sb.delete(0);
    end
    if (gmii_tx_en === 1'b1) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        checkOutput("out byte", {24'h0, gmii_txd}, {24'h0, sb[0].data});
        sb.delete(0);
      end else begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL out byte unexpected: got en=1 txd=%02h at cycle %0d expected en=0",
                 gmii_txd, cyc);
      end
      if (!prev_en && have_frame) checkOutput("ifg gap >= 12", {31'h0, idle_run >= IFG}, 1);
      have_frame = 1'b1;
      idle_run   = 0;
    end else begin
      checkOutput("idle txd zero", {24'h0, gmii_txd}, 0);
      idle_run++;
    end
    checkOutput("gnt exclusive", {31'h0, arp_tx_gnt & udp_tx_gnt}, 0);
    if (frame_abort === 1'b1) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    prev_en = gmii_tx_en;
  end

  task automatic applyStimulus(input vec_t v);
    arp_tx_req = v.arp_req;
    udp_tx_req = v.udp_req;
  endtask

  task automatic wait_gnt(input int max, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(arp_tx_gnt === 1'b1 || udp_tx_gnt === 1'b1) && lat < max);
    if (!(arp_tx_gnt === 1'b1 || udp_tx_gnt === 1'b1)) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL grant wait: got no grant after %0d cycles expected a grant", lat);
    end
  endtask

  // Drives a frame from src (0 ARP, 1 UDP); bytes with index below cut are expected at the output
  task automatic send_frame(input bit src, input int len, input int cut, input bit noise,
                            output int exp_abort);
    logic [7:0] b;
    exp_abort = -1;
    for (int i = 0; i < len; i++) begin
      b = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : 8'((i * 7 + (src ? 64 : 16)) & 255);
      if (src) begin
        udp_gmii_tx_en = 1'b1;
        udp_gmii_txd   = b;
      end else begin
        arp_gmii_tx_en = 1'b1;
        arp_gmii_txd   = b;
      end
      if (noise && i >= 10 && i < 30) begin
        if (src) begin arp_gmii_tx_en = 1'b1; arp_gmii_txd = 8'hAA; end
        else     begin udp_gmii_tx_en = 1'b1; udp_gmii_txd = 8'hAA; end
      end else begin
        if (src) begin arp_gmii_tx_en = 1'b0; arp_gmii_txd = 8'h00; end
        else     begin udp_gmii_tx_en = 1'b0; udp_gmii_txd = 8'h00; end
      end
      if (i < cut) sb.push_back('{cyc: cyc + 1, data: b});
      else if (i == cut) exp_abort = cyc + 1;
      tick();
      checkOutput(src ? "udp gnt held" : "arp gnt held", {31'h0, src ? udp_tx_gnt : arp_tx_gnt}, 1);
      checkOutput("other gnt low", {31'h0, src ? arp_tx_gnt : udp_tx_gnt}, 0);
    end
    arp_gmii_tx_en = 1'b0;
    arp_gmii_txd   = 8'h00;
    udp_gmii_tx_en = 1'b0;
    udp_gmii_txd   = 8'h00;
    if (src) udp_tx_req = 1'b0;
    else     arp_tx_req = 1'b0;
  endtask

  // Overall time limit
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    int lat, n, ab0, eab;
    bit win;

    // arp_req udp_req fresh len exp_arp exp_udp
    vecs[0] = '{1'b1, 1'b1, 1'b1, 16, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 16, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 64, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 20, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 20, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1,  8, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 10, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b1};

    rst            = 1'b1;
    arp_tx_req     = 1'b0;
    udp_tx_req     = 1'b0;
    arp_gmii_tx_en = 1'b0;
    arp_gmii_txd   = 8'h00;
    udp_gmii_tx_en = 1'b0;
    udp_gmii_txd   = 8'h00;
    repeat (3) tick();
    checkOutput("reset gmii_tx_en", {31'h0, gmii_tx_en}, 0);
    checkOutput("reset gmii_txd", {24'h0, gmii_txd}, 0);
    checkOutput("reset arp_gnt", {31'h0, arp_tx_gnt}, 0);
    checkOutput("reset udp_gnt", {31'h0, udp_tx_gnt}, 0);
    checkOutput("reset busy", {31'h0, busy}, 0);
    checkOutput("reset abort", {31'h0, frame_abort}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].fresh) repeat (20) tick();
      applyStimulus(vecs[i]);
      wait_gnt(60, lat);
      checkOutput($sformatf("vec%0d arp_gnt", i), {31'h0, arp_tx_gnt}, {31'h0, vecs[i].exp_arp_gnt});
      checkOutput($sformatf("vec%0d udp_gnt", i), {31'h0, udp_tx_gnt}, {31'h0, vecs[i].exp_udp_gnt});
      if (vecs[i].fresh) checkOutput($sformatf("vec%0d grant latency", i), lat, 1);
      win = vecs[i].exp_udp_gnt;
      send_frame(win, vecs[i].len, vecs[i].len, 1'b0, eab);
    end

    // Grant timeout: UDP holds its request but never sends
    repeat (20) tick();
    udp_tx_req = 1'b1;
    tick();
    checkOutput("timeout grant", {31'h0, udp_tx_gnt}, 1);
    n = 0;
    while (udp_tx_gnt === 1'b1 && n < 40) begin
      n++;
      checkOutput("timeout abort low", {31'h0, frame_abort}, 0);
      tick();
    end
    checkOutput("timeout grant cycles", n, TO);
    checkOutput("timeout busy", {31'h0, busy}, 0);
    udp_tx_req = 1'b0;

    // Oversize: 120 bytes against MAX_FRAME=100
    repeat (20) tick();
    arp_tx_req = 1'b1;
    wait_gnt(5, lat);
    checkOutput("oversize arp_gnt", {31'h0, arp_tx_gnt}, 1);
    ab0 = abort_cnt;
    send_frame(1'b0, 120, MAXF, 1'b0, eab);
    tick();
    checkOutput("drain exit gnt", {31'h0, arp_tx_gnt}, 0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    checkOutput("ifg busy cycles", n, IFG);
    checkOutput("abort pulses", abort_cnt - ab0, 1);
    checkOutput("abort cycle", abort_cyc, eab);

    // Foreign source noise during an ARP frame, then stale ARP pulses during IFG
    repeat (20) tick();
    arp_tx_req = 1'b1;
    wait_gnt(5, lat);
    checkOutput("noise arp_gnt", {31'h0, arp_tx_gnt}, 1);
    send_frame(1'b0, 48, 48, 1'b1, eab);
    tick();
    arp_gmii_tx_en = 1'b1;
    arp_gmii_txd   = 8'h77;
    repeat (3) tick();
    arp_gmii_tx_en = 1'b0;
    arp_gmii_txd   = 8'h00;

    // Reset at byte 30 of an ARP frame
    repeat (20) tick();
    arp_tx_req = 1'b1;
    wait_gnt(5, lat);
    for (int i = 0; i < 30; i++) begin
      arp_gmii_tx_en = 1'b1;
      arp_gmii_txd   = 8'(i + 8'h30);
      sb.push_back('{cyc: cyc + 1, data: 8'(i + 8'h30)});
      tick();
    end
    arp_gmii_txd = 8'hEE;
    rst = 1'b1;
    tick();
    checkOutput("midrst gmii_tx_en", {31'h0, gmii_tx_en}, 0);
    checkOutput("midrst gmii_txd", {24'h0, gmii_txd}, 0);
    checkOutput("midrst arp_gnt", {31'h0, arp_tx_gnt}, 0);
    checkOutput("midrst udp_gnt", {31'h0, udp_tx_gnt}, 0);
    checkOutput("midrst busy", {31'h0, busy}, 0);
    rst        = 1'b0;
    arp_tx_req = 1'b0;
    repeat (4) tick();
    arp_gmii_tx_en = 1'b0;
    arp_gmii_txd   = 8'h00;
    repeat (20) tick();
    arp_tx_req = 1'b1;
    udp_tx_req = 1'b1;
    wait_gnt(5, lat);
    checkOutput("post-reset tie arp_gnt", {31'h0, arp_tx_gnt}, 1);
    checkOutput("post-reset tie udp_gnt", {31'h0, udp_tx_gnt}, 0);
    send_frame(1'b0, 16, 16, 1'b0, eab);
    wait_gnt(60, lat);
    checkOutput("post-reset second udp_gnt", {31'h0, udp_tx_gnt}, 1);
    send_frame(1'b1, 16, 16, 1'b0, eab);

    repeat (30) tick();
    checkOutput("scoreboard drained", sb.size(), 0);
    checkOutput("total aborts", abort_cnt, 1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
